// File: rtl/frame_deserializer_pkg.sv
// Shared defaults and state encoding for the serial frame deserializer.
// Frames are a sync header followed by an MSB-first payload.
package frame_deserializer_pkg;

    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_SYNC_W   = 2;
    localparam logic [1:0]  DEF_SYNC_PAT = 2'b11;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

endpackage : frame_deserializer_pkg

// File: rtl/frame_deserializer.sv
// Serial-to-parallel receiver: hunts for the sync header on a 1-bit stream, then
// captures DATA_W payload bits MSB-first and presents them with a one-cycle strobe.
module frame_deserializer
    import frame_deserializer_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              state, state_nx;
    logic [SYNC_W-1:0]   hist, hist_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [DATA_W-1:0]   shift, shift_nx;
    logic [DATA_W-1:0]   out_nx;
    logic                valid_nx;
    logic [SYNC_W-1:0]   window;

    // Window seen on this edge: stored history plus the bit being sampled now.
    assign window = {hist[SYNC_W-2:0], data_in};

    // NOTE: every output of this block is given a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        cnt_nx   = cnt;
        shift_nx = shift;
        out_nx   = data_out;
        valid_nx = 1'b0;

        unique case (state)
            HUNT: begin
                hist_nx = window;
                if (window == SYNC_PAT) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end
            end
            CAPTURE: begin
                shift_nx = {shift[DATA_W-2:0], data_in};
                cnt_nx   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    out_nx   = shift_nx;
                    valid_nx = 1'b1;
                    state_nx = HUNT;
                    // Payload bits must not seed the next header search.
                    hist_nx  = '0;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            hist       <= '0;
            cnt        <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            hist       <= hist_nx;
            cnt        <= cnt_nx;
            shift      <= shift_nx;
            data_out   <= out_nx;
            data_valid <= valid_nx;
        end
    end

endmodule : frame_deserializer

// File: tb/tb_frame_deserializer.sv
// Directed self-checking bench for frame_deserializer: header hunting, capture,
// back-to-back frames, payload containing the header pattern and mid-frame reset.
module tb_frame_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_in = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, sampled 1 ns after each rising edge
    int          edge_cnt  = 0;
    int          pulse_cnt = 0;
    int          last_edge = 0;
    logic [31:0] last_val  = '0;

    frame_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (data_valid === 1'b1) begin
            pulse_cnt++;
            last_val  = data_out;
            last_edge = edge_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one bit at the falling edge; return once it has been sampled and monitored.
    task automatic send_bit(input logic b);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    int hdr_edge;
    int base_pulses;
    int first_edge;

    initial begin
        // Reset held for 10 cycles, then an idle-low line
        rst     = 1'b1;
        data_in = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_data_out", data_out, 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);
        rst = 1'b0;
        send_zeros(50);
        check("idle_data_out", data_out, 32'h0);
        check("idle_pulses", 32'(pulse_cnt), 32'd0);

        // Header then 0,1,1,0,1,1 and 26 zeros -> 0x6C000000
        send_bit(1'b1);
        hdr_edge = edge_cnt;
        send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_zeros(20);
        check("partial_not_visible", data_out, 32'h0);
        check("partial_no_pulse", 32'(pulse_cnt), 32'd0);
        send_zeros(6);
        check("f6c_pulses", 32'(pulse_cnt), 32'd1);
        check("f6c_value", last_val, 32'h6C00_0000);
        check("f6c_latency", 32'(last_edge - hdr_edge), 32'd33);
        send_zeros(50);
        check("f6c_hold", data_out, 32'h6C00_0000);
        check("f6c_single_pulse", 32'(pulse_cnt), 32'd1);

        // Sliding-window header: 0,1,0,1,1 matches on the 5th bit
        base_pulses = pulse_cnt;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_zeros(28);
        check("slide_no_early", 32'(pulse_cnt - base_pulses), 32'd0);
        send_zeros(1);
        check("slide_pulses", 32'(pulse_cnt - base_pulses), 32'd1);
        check("slide_value", data_out, 32'h4000_0000);

        // Back-to-back frames, second header immediately after the first payload
        base_pulses = pulse_cnt;
        send_bit(1'b1); send_bit(1'b1);
        send_word(32'hDEAD_BEEF);
        check("b2b_first_value", data_out, 32'hDEAD_BEEF);
        check("b2b_first_pulse", 32'(pulse_cnt - base_pulses), 32'd1);
        first_edge = last_edge;
        send_bit(1'b1); send_bit(1'b1);
        send_word(32'h1234_5678);
        check("b2b_second_value", data_out, 32'h1234_5678);
        check("b2b_second_pulse", 32'(pulse_cnt - base_pulses), 32'd2);
        check("b2b_spacing", 32'(last_edge - first_edge), 32'd34);

        // All-ones payload must not terminate early or re-sync
        send_zeros(3);
        base_pulses = pulse_cnt;
        send_bit(1'b1);
        hdr_edge = edge_cnt;
        send_bit(1'b1);
        send_word(32'hFFFF_FFFF);
        check("ones_value", data_out, 32'hFFFF_FFFF);
        check("ones_latency", 32'(last_edge - hdr_edge), 32'd33);
        check("ones_pulses", 32'(pulse_cnt - base_pulses), 32'd1);
        // History is cleared after a frame: one lone 1 must not start a capture
        send_bit(1'b1);
        send_zeros(40);
        check("ones_no_resync", 32'(pulse_cnt - base_pulses), 32'd1);
        check("ones_hold", data_out, 32'hFFFF_FFFF);

        // Reset during capture discards the partial frame immediately
        base_pulses = pulse_cnt;
        send_bit(1'b1); send_bit(1'b1);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_valid", 32'(data_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_zeros(30);
        check("midrst_no_pulse", 32'(pulse_cnt - base_pulses), 32'd0);
        check("midrst_hold", data_out, 32'h0);
        send_bit(1'b1); send_bit(1'b1);
        send_word(32'hA5A5_A5A5);
        check("after_rst_value", data_out, 32'hA5A5_A5A5);
        check("after_rst_pulse", 32'(pulse_cnt - base_pulses), 32'd1);
        send_zeros(2);
        check("valid_low_after", 32'(data_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_frame_deserializer
